// File: rtl/approx_compressor_error_monitor.sv
// approx_compressor_error_monitor
//
// Characterises an 8:2 approximate compressor. For every accepted sample it
// recomputes the exact population count of the operand vector, takes the
// absolute error distance against the compressor's 2-bit result, and folds
// that distance into statistics gathered over a programmed sample window.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         one-cycle pulse: clear statistics, open a window
//   num_samples   window length, captured on an accepted start
//   in_valid      sample valid
//   in_ready      monitor can accept a sample
//   in_vec        operand vector fed to the compressor
//   approx_sum    compressor result (bit1 weight 2, bit0 weight 1)
//   busy          window open or pipeline draining
//   done          statistics final; held until the next accepted start
//   sample_cnt    samples committed
//   err_cnt       samples whose error distance is non-zero
//   ed_sum        saturating sum of error distances
//   ed_max        largest error distance seen (0..8)
module approx_compressor_error_monitor #(
  parameter int CNT_W = 16,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_vec,
  input  logic [1:0]       approx_sum,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [ACC_W-1:0] ed_sum,
  output logic [3:0]       ed_max
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] target_reg;
  logic [CNT_W-1:0] accept_cnt_reg;
  logic [CNT_W-1:0] accept_cnt_next;

  // Stage 1: exact popcount and approximate value.
  logic             s1_valid_reg;
  logic [3:0]       s1_exact_reg;
  logic [1:0]       s1_approx_reg;
  // Stage 2: error distance.
  logic             s2_valid_reg;
  logic [3:0]       s2_ed_reg;

  logic             accept;
  logic [3:0]       popcount;
  logic [3:0]       ed_next;
  logic [ACC_W:0]   ed_sum_wide;
  logic [ACC_W-1:0] ed_sum_next;

  assign accept          = in_valid && in_ready;
  assign accept_cnt_next = accept_cnt_reg + 1'b1;

  // Ripple popcount as a chain of partial sums over the operand bits.
  logic [3:0] pc_partial [0:8];
  assign pc_partial[0] = 4'd0;
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_popcount
      assign pc_partial[gi+1] = pc_partial[gi] + {3'b000, in_vec[gi]};
    end
  endgenerate
  assign popcount = pc_partial[8];

  // approx_sum already encodes 2*b1 + b0 as an unsigned value.
  assign ed_next = (s1_exact_reg >= {2'b00, s1_approx_reg})
                 ? s1_exact_reg - {2'b00, s1_approx_reg}
                 : {2'b00, s1_approx_reg} - s1_exact_reg;

  // One extra bit catches the carry; once set, the sum pins at all-ones.
  assign ed_sum_wide = {1'b0, ed_sum} + {{(ACC_W-3){1'b0}}, s2_ed_reg};
  assign ed_sum_next = ed_sum_wide[ACC_W] ? {ACC_W{1'b1}} : ed_sum_wide[ACC_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      target_reg     <= '0;
      accept_cnt_reg <= '0;
      s1_valid_reg   <= 1'b0;
      s1_exact_reg   <= '0;
      s1_approx_reg  <= '0;
      s2_valid_reg   <= 1'b0;
      s2_ed_reg      <= '0;
      in_ready       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      sample_cnt     <= '0;
      err_cnt        <= '0;
      ed_sum         <= '0;
      ed_max         <= '0;
    end else begin
      // Pipeline runs freely; no internal backpressure.
      s1_valid_reg <= accept;
      if (accept) begin
        s1_exact_reg  <= popcount;
        s1_approx_reg <= approx_sum;
      end
      s2_valid_reg <= s1_valid_reg;
      s2_ed_reg    <= ed_next;

      if (s2_valid_reg) begin
        sample_cnt <= sample_cnt + 1'b1;
        if (s2_ed_reg != 4'd0) err_cnt <= err_cnt + 1'b1;
        ed_sum <= ed_sum_next;
        if (s2_ed_reg > ed_max) ed_max <= s2_ed_reg;
      end

      case (state_reg)
        IDLE, DONE: begin
          // The pipeline is always empty here, so clearing cannot race a commit.
          if (start) begin
            target_reg     <= num_samples;
            accept_cnt_reg <= '0;
            sample_cnt     <= '0;
            err_cnt        <= '0;
            ed_sum         <= '0;
            ed_max         <= '0;
            done           <= 1'b0;
            busy           <= 1'b1;
            if (num_samples == '0) begin
              state_reg <= DRAIN;
              in_ready  <= 1'b0;
            end else begin
              state_reg <= RUN;
              in_ready  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            accept_cnt_reg <= accept_cnt_next;
            if (accept_cnt_next == target_reg) begin
              in_ready  <= 1'b0;
              state_reg <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!s1_valid_reg && !s2_valid_reg) begin
            state_reg <= DONE;
            done      <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_compressor_error_monitor.sv
// Scoreboard bench for approx_compressor_error_monitor. Window results are
// queued when a window is issued and popped by a monitor when done rises;
// accept cycles are queued and popped when sample_cnt steps, to check latency.
module tb_approx_compressor_error_monitor;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_samples = '0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_vec = '0;
  logic [1:0]       approx_sum = '0;

  logic             in_ready, busy, done;
  logic [CNT_W-1:0] sample_cnt, err_cnt;
  logic [23:0]      ed_sum;
  logic [3:0]       ed_max;

  // Narrow-accumulator instance sharing the same stimulus.
  logic             s_in_ready, s_busy, s_done;
  logic [CNT_W-1:0] s_sample_cnt, s_err_cnt;
  logic [3:0]       s_ed_sum;
  logic [3:0]       s_ed_max;

  approx_compressor_error_monitor #(.CNT_W(CNT_W), .ACC_W(24)) dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .approx_sum(approx_sum), .busy(busy), .done(done),
    .sample_cnt(sample_cnt), .err_cnt(err_cnt), .ed_sum(ed_sum), .ed_max(ed_max)
  );

  approx_compressor_error_monitor #(.CNT_W(CNT_W), .ACC_W(4)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_vec(in_vec),
    .approx_sum(approx_sum), .busy(s_busy), .done(s_done),
    .sample_cnt(s_sample_cnt), .err_cnt(s_err_cnt), .ed_sum(s_ed_sum), .ed_max(s_ed_max)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int err;
    int sum;
    int mx;
    int sat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic [7:0] vecs [8];
  logic [1:0] aps  [8];

  task automatic check(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Window monitor: one transaction per rising edge of done.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    done_prev <= done;
    if (done && !done_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("window: sample_cnt=%0d err_cnt=%0d ed_sum=%0d ed_max=%0d sat_ed_sum=%0d",
                 sample_cnt, err_cnt, ed_sum, ed_max, s_ed_sum);
        check("sample_cnt", sample_cnt, e.cnt);
        check("err_cnt", err_cnt, e.err);
        check("ed_sum", ed_sum, e.sum);
        check("ed_max", ed_max, e.mx);
        check("sat_ed_sum", s_ed_sum, e.sat);
      end
    end
  end

  // Latency monitor: each commit must appear three cycles after its accept.
  logic [CNT_W-1:0] prev_cnt = '0;
  always @(negedge clk) begin
    prev_cnt <= sample_cnt;
    if (!rst && sample_cnt == prev_cnt + 16'd1) begin
      if (acc_q.size() == 0) check("commit_without_accept", 1, 0);
      else check("commit_latency", cyc - acc_q.pop_front(), 3);
    end
    if (rst) acc_q.delete();
    else if (in_valid && in_ready) acc_q.push_back(cyc);
  end

  task automatic check_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_sample_cnt"}, sample_cnt, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
    check({tag, "_ed_sum"}, ed_sum, 0);
    check({tag, "_ed_max"}, ed_max, 0);
  endtask

  task automatic push_exp(input int cnt, input int err, input int sum, input int mx, input int sat);
    exp_t e;
    e.cnt = cnt; e.err = err; e.sum = sum; e.mx = mx; e.sat = sat;
    exp_q.push_back(e);
  endtask

  // Issue a window of n samples from vecs/aps. toggle gaps in_valid every
  // other cycle; extra holds in_valid high after the last accept; midstart
  // (>=0) pulses start alongside that sample index.
  task automatic run_window(input int n, input bit toggle, input int extra, input int midstart);
    int  i = 0;
    int  guard = 0;
    bit  ph = 1'b0;
    bit  mid_done = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    num_samples = CNT_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("busy_after_start", busy, 1);
    while (i < n) begin
      @(posedge clk); #1;
      if (midstart >= 0 && i == midstart && !mid_done) begin
        start = 1'b1;
        num_samples = 16'd1;
        mid_done = 1'b1;
      end else begin
        start = 1'b0;
      end
      in_valid   = toggle ? ph : 1'b1;
      ph         = ~ph;
      in_vec     = vecs[i];
      approx_sum = aps[i];
      @(negedge clk);
      if (in_valid && in_ready) i++;
      guard++;
      if (guard > 200) begin
        check("accept_timeout", i, n);
        break;
      end
    end
    for (int k = 0; k < extra; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      in_valid = 1'b1;
      in_vec = 8'hFF;
      approx_sum = 2'b00;
      @(negedge clk);
      check("in_ready_after_last", in_ready, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    start = 1'b0;
    guard = 0;
    while (!done) begin
      @(negedge clk);
      if (n == 0) check("in_ready_empty_window", in_ready, 0);
      guard++;
      if (guard > 50) begin
        check("done_timeout", done, 1);
        break;
      end
    end
    @(negedge clk);
    check("busy_after_done", busy, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("idle");

    // 8 ones vs approx 3 -> ed 5.
    vecs[0] = 8'hFF; aps[0] = 2'b11;
    push_exp(1, 1, 5, 5, 5);
    run_window(1, 1'b0, 0, -1);

    // All exact.
    vecs[0] = 8'h07; aps[0] = 2'b11;
    vecs[1] = 8'h01; aps[1] = 2'b01;
    vecs[2] = 8'h00; aps[2] = 2'b00;
    push_exp(3, 0, 0, 0, 0);
    run_window(3, 1'b0, 0, -1);

    // Gapped valid, held past the window: ed 2,2,3,1.
    vecs[0] = 8'h0F; aps[0] = 2'b10;
    vecs[1] = 8'h03; aps[1] = 2'b00;
    vecs[2] = 8'hF0; aps[2] = 2'b01;
    vecs[3] = 8'hAA; aps[3] = 2'b11;
    push_exp(4, 4, 8, 3, 8);
    run_window(4, 1'b1, 3, -1);

    // Empty window.
    push_exp(0, 0, 0, 0, 0);
    run_window(0, 1'b0, 0, -1);

    // ed 8 each: 24 on the wide accumulator, 15 on the narrow one.
    for (int k = 0; k < 3; k++) begin
      vecs[k] = 8'hFF; aps[k] = 2'b00;
    end
    push_exp(3, 3, 24, 8, 15);
    run_window(3, 1'b0, 0, -1);

    // Reset mid-window: two samples in flight are discarded.
    @(posedge clk); #1;
    start = 1'b1;
    num_samples = 16'd5;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    in_vec = 8'hFF;
    approx_sum = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("abort");
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("abort_no_commit", sample_cnt, 0);

    // start during RUN is ignored: ed 1,1,5,3.
    vecs[0] = 8'h01; aps[0] = 2'b00;
    vecs[1] = 8'h03; aps[1] = 2'b11;
    vecs[2] = 8'h7F; aps[2] = 2'b10;
    vecs[3] = 8'h00; aps[3] = 2'b11;
    push_exp(4, 4, 10, 5, 10);
    run_window(4, 1'b0, 0, 2);

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("windows_outstanding", exp_q.size(), 0);
    check("accepts_outstanding", acc_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
